iddr_deser: RTL and testbench

IDDR_DESER -- requirements
Module: iddr_deser

---
 rtl/ddr_pkg.sv | 11 +
 rtl/iddr_core.sv | 63 ++++++
 rtl/iddr_deser.sv | 74 +++++++
 tb/tb_iddr_deser.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// ddr_pkg: shared edge-mode names and gearbox geometry for the DDR input path
package ddr_pkg;
    localparam string EDGE_OPPOSITE       = "OPPOSITE_EDGE";
    localparam string EDGE_SAME           = "SAME_EDGE";
    localparam string EDGE_SAME_PIPELINED = "SAME_EDGE_PIPELINED";
    localparam int WORD_W       = 8;
    localparam int BITS_PER_CLK = 2;
    localparam int SR_W         = WORD_W + BITS_PER_CLK;
    localparam int CNT_W        = $clog2(WORD_W / BITS_PER_CLK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W / BITS_PER_CLK - 1);
endpackage

// File: rtl/iddr_core.sv
// iddr_core: dual-edge capture of d with mode-dependent q1/q2 and a rise-aligned bit pair
module iddr_core import ddr_pkg::*; #(
    parameter string DDR_CLK_EDGE = EDGE_OPPOSITE,
    parameter logic  INIT_Q1      = 1'b0,
    parameter logic  INIT_Q2      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic d,
    output logic q1,
    output logic q2,
    output logic pair_a,
    output logic pair_b
);
    localparam bit IS_OPP  = DDR_CLK_EDGE == EDGE_OPPOSITE;
    localparam bit IS_SAME = DDR_CLK_EDGE == EDGE_SAME;

    logic r_pos;
    logic r_neg;
    logic q1_src;

    assign q1_src = IS_SAME ? d : r_pos;

    // rising-edge sample and the previous full pair re-timed onto the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos  <= 1'b0;
            pair_a <= 1'b0;
            pair_b <= 1'b0;
        end else if (ce) begin
            r_pos  <= d;
            pair_a <= r_pos;
            pair_b <= r_neg;
        end
    end

    // falling-edge sample completing the pair started at the preceding rising edge
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) r_neg <= 1'b0;
        else if (ce) r_neg <= d;
    end

    // q1 always presents on the rising edge; SAME_EDGE takes the bit being sampled now
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q1 <= INIT_Q1;
        else if (ce) q1 <= q1_src;
    end

    if (IS_OPP) begin : g_q2_fall
        // opposite-edge mode presents the falling sample on the falling edge
        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) q2 <= INIT_Q2;
            else if (ce) q2 <= d;
        end
    end else begin : g_q2_rise
        // same-edge modes move the falling sample onto the next rising edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q2 <= INIT_Q2;
            else if (ce) q2 <= r_neg;
        end
    end
endmodule

// File: rtl/iddr_deser.sv
// iddr_deser: DDR input capture followed by a 2-to-8 bit gearbox with bitslip alignment
module iddr_deser import ddr_pkg::*; #(
    parameter string DDR_CLK_EDGE = EDGE_OPPOSITE,
    parameter logic  INIT_Q1      = 1'b0,
    parameter logic  INIT_Q2      = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              d,
    input  logic              bitslip,
    output logic              q1,
    output logic              q2,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);
    logic              pair_a;
    logic              pair_b;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_next;
    logic [CNT_W-1:0]  cnt;
    logic              offset;
    logic              hold;
    logic              slip;
    logic              wrap;
    logic [WORD_W-1:0] win;

    iddr_core #(
        .DDR_CLK_EDGE(DDR_CLK_EDGE),
        .INIT_Q1     (INIT_Q1),
        .INIT_Q2     (INIT_Q2)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .d     (d),
        .q1    (q1),
        .q2    (q2),
        .pair_a(pair_a),
        .pair_b(pair_b)
    );

    // newest pair enters at the top; window sits one bit lower when offset is clear
    always_comb begin
        sr_next = (sr >> BITS_PER_CLK) | {pair_b, pair_a, {WORD_W{1'b0}}};
        slip    = ce & bitslip & ~hold;
        wrap    = ~hold & (cnt == CNT_LAST);
        win     = WORD_W'(sr_next >> (offset ? 2 : 1));
    end

    // shift, count pairs, emit a word every fourth counted shift; a 1->0 slip skips one count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= '0;
            cnt        <= '0;
            offset     <= 1'b0;
            hold       <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (ce) begin
                sr     <= sr_next;
                cnt    <= hold ? cnt : cnt + 1'b1;
                hold   <= slip & offset;
                offset <= offset ^ slip;
                if (wrap) begin
                    word       <= win;
                    word_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_iddr_deser.sv
// tb_iddr_deser: directed scoreboard bench for edge modes, gearbox, bitslip, ce gating and reset
module tb_iddr_deser;
    import ddr_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       d;
    logic       bitslip;
    logic [2:0] q1_v;
    logic [2:0] q2_v;
    logic [2:0] wv_v;
    logic [7:0] word_v [3];

    int         checks;
    int         errors;
    int         bi;
    logic       bits [256];
    logic [7:0] exp_q [$];

    iddr_deser #(.DDR_CLK_EDGE(EDGE_OPPOSITE), .INIT_Q1(1'b1), .INIT_Q2(1'b0)) dut_opp (
        .clk(clk), .rst_n(rst_n), .ce(ce), .d(d), .bitslip(bitslip),
        .q1(q1_v[0]), .q2(q2_v[0]), .word(word_v[0]), .word_valid(wv_v[0]));
    iddr_deser #(.DDR_CLK_EDGE(EDGE_SAME), .INIT_Q1(1'b1), .INIT_Q2(1'b0)) dut_same (
        .clk(clk), .rst_n(rst_n), .ce(ce), .d(d), .bitslip(bitslip),
        .q1(q1_v[1]), .q2(q2_v[1]), .word(word_v[1]), .word_valid(wv_v[1]));
    iddr_deser #(.DDR_CLK_EDGE(EDGE_SAME_PIPELINED), .INIT_Q1(1'b1), .INIT_Q2(1'b0)) dut_pipe (
        .clk(clk), .rst_n(rst_n), .ce(ce), .d(d), .bitslip(bitslip),
        .q1(q1_v[2]), .q2(q2_v[2]), .word(word_v[2]), .word_valid(wv_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every emitted word must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && wv_v[0]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL word_unexpected observed=%0h expected=none", word_v[0]);
            end else begin
                chk("word", 32'(word_v[0]), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic rise_half(input logic a, input logic ce_i, input logic slip_i);
        d = a;
        ce = ce_i;
        bitslip = slip_i;
        @(posedge clk);
        #1;
        bitslip = 1'b0;
    endtask

    task automatic fall_half(input logic b);
        d = b;
        @(negedge clk);
        #1;
    endtask

    task automatic gstep(input logic ce_i, input logic slip_i, output logic wv);
        logic a;
        logic b;
        if (ce_i) begin
            a = bits[bi];
            b = bits[bi + 1];
            bi += 2;
        end else begin
            a = 1'($urandom);
            b = 1'($urandom);
        end
        rise_half(a, ce_i, slip_i);
        wv = wv_v[0];
        fall_half(b);
    endtask

    task automatic wait_wv(input int start, output int n);
        logic wv;
        n = start;
        do begin
            gstep(1'b1, 1'b0, wv);
            n++;
        end while (!wv && n < 12);
    endtask

    initial begin
        logic       wv;
        int         n;
        int         n0;
        logic [7:0] b0;
        logic [7:0] b1;
        checks  = 0;
        errors  = 0;
        bi      = 0;
        b0      = 8'hA5;
        b1      = 8'h3C;
        for (int i = 0; i < 256; i++)
            bits[i] = i < 3 ? 1'b0 : i < 11 ? b0[i-3] : i < 19 ? b1[i-11] : ((i - 19) % 8 == 0);
        rst_n   = 1'b1;
        ce      = 1'b1;
        d       = 1'b0;
        bitslip = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_q1", 32'(q1_v[i]), 32'd1);
            chk("rst_q2", 32'(q2_v[i]), 32'd0);
        end
        chk("rst_wv", 32'(wv_v[0]), 32'd0);
        chk("rst_word", 32'(word_v[0]), 32'd0);
        #1 rst_n = 1'b1;

        // edge modes: pairs (0,1), (1,0), (1,0)
        rise_half(1'b0, 1'b1, 1'b0);
        chk("same_q1_e1", 32'(q1_v[1]), 32'd0);
        chk("same_q2_e1", 32'(q2_v[1]), 32'd0);
        chk("pipe_q1_e1", 32'(q1_v[2]), 32'd0);
        chk("pipe_q2_e1", 32'(q2_v[2]), 32'd0);
        fall_half(1'b1);
        chk("opp_q2_f1", 32'(q2_v[0]), 32'd1);
        chk("same_q2_f1", 32'(q2_v[1]), 32'd0);
        rise_half(1'b1, 1'b1, 1'b0);
        chk("same_q1_e2", 32'(q1_v[1]), 32'd1);
        chk("same_q2_e2", 32'(q2_v[1]), 32'd1);
        chk("pipe_q1_e2", 32'(q1_v[2]), 32'd0);
        chk("pipe_q2_e2", 32'(q2_v[2]), 32'd1);
        fall_half(1'b0);
        chk("opp_q2_f2", 32'(q2_v[0]), 32'd0);
        rise_half(1'b1, 1'b1, 1'b0);
        chk("same_q1_e3", 32'(q1_v[1]), 32'd1);
        chk("same_q2_e3", 32'(q2_v[1]), 32'd0);
        chk("pipe_q1_e3", 32'(q1_v[2]), 32'd1);
        chk("pipe_q2_e3", 32'(q2_v[2]), 32'd0);
        chk("opp_q1_e3", 32'(q1_v[0]), 32'd1);
        chk("opp_q2_e3", 32'(q2_v[0]), 32'd0);
        fall_half(1'b0);

        // reset mid-word discards the three pairs already shifted
        rst_n = 1'b0;
        #1;
        chk("midword_rst_wv", 32'(wv_v[0]), 32'd0);
        #2 rst_n = 1'b1;

        // gearbox: 3 zero bits, 0xA5, 0x3C, then 0x01 repeating, LSB first
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        repeat (9) gstep(1'b1, 1'b0, wv);
        repeat (3) begin
            gstep(1'b0, 1'b1, wv);
            chk("ce_low_wv", 32'(wv), 32'd0);
            chk("ce_low_word", 32'(word_v[0]), 32'hA5);
        end
        repeat (10) gstep(1'b1, 1'b0, wv);
        gstep(1'b1, 1'b1, wv);
        chk("collision_wv", 32'(wv), 32'd1);
        wait_wv(0, n);
        chk("gap_after_collision", 32'(n), 32'd4);

        // seven more slips, one right after each word
        for (int k = 2; k <= 8; k++) begin
            exp_q.push_back(8'(1 << (8 - k)));
            gstep(1'b1, 1'b1, wv);
            chk("slip_step_wv", 32'(wv), 32'd0);
            n0 = 0;
            if (k == 2) begin
                gstep(1'b1, 1'b1, wv);
                n0 = 1;
            end
            wait_wv(n0, n);
            chk("slip_gap", 32'(n), (k % 2) ? 32'd3 : 32'd4);
        end
        exp_q.push_back(8'h01);
        wait_wv(0, n);
        chk("gap_after_8_slips", 32'(n), 32'd4);

        // asynchronous reset while word_valid is high
        chk("pre_reset_wv", 32'(wv_v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_wv", 32'(wv_v[0]), 32'd0);
        chk("async_rst_word", 32'(word_v[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("async_rst_q1", 32'(q1_v[i]), 32'd1);
            chk("async_rst_q2", 32'(q2_v[i]), 32'd0);
        end
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
